// File: rtl/alu_operand_seq.sv
// Front-end control for the 4-bit ALU: debounced buttons load A/B, step S, and run a
// settle-then-capture cycle into res/res_co/res_valid. Define ACC_FEEDBACK_EN to add btn_acc.
module alu_operand_seq #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned DB_CYCLES  = 4,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_a,
    input  logic             btn_b,
    input  logic             btn_op,
    input  logic             btn_go,
`ifdef ACC_FEEDBACK_EN
    input  logic             btn_acc,
`endif
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [1:0]       S,
    input  logic [WIDTH-1:0] C_in,
    input  logic             Co_in,
    output logic [WIDTH-1:0] res,
    output logic             res_co,
    output logic             res_valid,
    output logic             busy
);

    localparam int unsigned BtnA  = 0;
    localparam int unsigned BtnB  = 1;
    localparam int unsigned BtnOp = 2;
    localparam int unsigned BtnGo = 3;
`ifdef ACC_FEEDBACK_EN
    localparam int unsigned BtnAcc = 4;
    localparam int unsigned NBTN   = 5;
`else
    localparam int unsigned NBTN   = 4;
`endif

    localparam int unsigned CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned SCW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0]  DbLast     = CW'(DB_CYCLES - 1);
    localparam logic [SCW-1:0] SettleLast = SCW'(SETTLE_CYC - 1);

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    logic [NBTN-1:0]          btn_raw;
    logic [NBTN-1:0]          sync0_q, sync1_q;
    logic [NBTN-1:0]          db_q, db_d;
    logic [NBTN-1:0]          db_dly_q;
    logic [NBTN-1:0]          press_q, press_d;
    logic [NBTN-1:0][CW-1:0]  cnt_q, cnt_d;

    state_e                   state_q, state_d;
    logic [SCW-1:0]           settle_q, settle_d;
    logic [WIDTH-1:0]         a_q, a_d;
    logic [WIDTH-1:0]         b_q, b_d;
    logic [1:0]               s_q, s_d;
    logic [WIDTH-1:0]         res_q, res_d;
    logic                     res_co_q, res_co_d;
    logic                     res_valid_q, res_valid_d;
    logic                     any_load;

`ifdef ACC_FEEDBACK_EN
    assign btn_raw = {btn_acc, btn_go, btn_op, btn_b, btn_a};
`else
    assign btn_raw = {btn_go, btn_op, btn_b, btn_a};
`endif

    // Debounce: a level change is accepted only after DB_CYCLES consecutive differing samples.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < int'(NBTN); i++) begin
            if (sync1_q[i] != db_q[i]) begin
                if (cnt_q[i] == DbLast) begin
                    db_d[i]  = ~db_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
        // Rising edge of the debounced level, registered so the FSM sees a flop output.
        press_d = db_q & ~db_dly_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0_q  <= '0;
            sync1_q  <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            press_q  <= '0;
            cnt_q    <= '0;
        end else begin
            sync0_q  <= btn_raw;
            sync1_q  <= sync0_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        res_d       = res_q;
        res_co_d    = res_co_q;
        res_valid_d = res_valid_q;
        any_load    = 1'b0;

        case (state_q)
            StIdle: begin
                if (press_q[BtnA]) begin
                    a_d      = sw;
                    any_load = 1'b1;
                end
`ifdef ACC_FEEDBACK_EN
                // Accumulator feedback overrides a coincident switch load.
                if (press_q[BtnAcc] && res_valid_q) begin
                    a_d      = res_q;
                    any_load = 1'b1;
                end
`endif
                if (press_q[BtnB]) begin
                    b_d      = sw;
                    any_load = 1'b1;
                end
                if (press_q[BtnOp]) begin
                    s_d      = s_q + 2'd1;
                    any_load = 1'b1;
                end
                if (any_load) begin
                    res_valid_d = 1'b0;
                end
                if (press_q[BtnGo]) begin
                    state_d  = StExec;
                    settle_d = '0;
                end
            end
            StExec: begin
                if (settle_q == SettleLast) begin
                    res_d       = C_in;
                    res_co_d    = Co_in;
                    res_valid_d = 1'b1;
                    settle_d    = '0;
                    state_d     = StIdle;
                end else begin
                    settle_d = settle_q + SCW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            settle_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            res_q       <= '0;
            res_co_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            res_q       <= res_d;
            res_co_q    <= res_co_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign S         = s_q;
    assign res       = res_q;
    assign res_co    = res_co_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q == StExec);

endmodule

// File: tb/tb_alu_operand_seq.sv
// Bench for alu_operand_seq: directed timing checks plus random presses against a
// transaction-level model; a second instance with SETTLE_CYC=3 covers busy lockout.
module tb_alu_operand_seq;

    localparam int DB = 4;
`ifdef ACC_FEEDBACK_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic [4:0] btn1;
    logic [4:0] btn3;

    logic [3:0] a1, b1, c1, res1;
    logic [1:0] s1;
    logic       co1, res_co1, valid1, busy1;
    logic [3:0] a3, b3, c3, res3;
    logic [1:0] s3;
    logic       co3, res_co3, valid3, busy3;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state (transaction level).
    logic [3:0] m_a, m_b, m_res;
    logic [1:0] m_s;
    logic       m_co, m_valid;

    always #5 clk = ~clk;

    function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] s);
        case (s)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    always_comb {co1, c1} = alu_ref(a1, b1, s1);
    always_comb {co3, c3} = alu_ref(a3, b3, s3);

    alu_operand_seq #(.WIDTH(4), .DB_CYCLES(DB), .SETTLE_CYC(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn_a     (btn1[0]),
        .btn_b     (btn1[1]),
        .btn_op    (btn1[2]),
        .btn_go    (btn1[3]),
`ifdef ACC_FEEDBACK_EN
        .btn_acc   (btn1[4]),
`endif
        .A         (a1),
        .B         (b1),
        .S         (s1),
        .C_in      (c1),
        .Co_in     (co1),
        .res       (res1),
        .res_co    (res_co1),
        .res_valid (valid1),
        .busy      (busy1)
    );

    alu_operand_seq #(.WIDTH(4), .DB_CYCLES(DB), .SETTLE_CYC(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn_a     (btn3[0]),
        .btn_b     (btn3[1]),
        .btn_op    (btn3[2]),
        .btn_go    (btn3[3]),
`ifdef ACC_FEEDBACK_EN
        .btn_acc   (btn3[4]),
`endif
        .A         (a3),
        .B         (b3),
        .S         (s3),
        .C_in      (c3),
        .Co_in     (co3),
        .res       (res3),
        .res_co    (res_co3),
        .res_valid (valid3),
        .busy      (busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".A"}, 32'(a1), 32'(m_a));
        check({tag, ".B"}, 32'(b1), 32'(m_b));
        check({tag, ".S"}, 32'(s1), 32'(m_s));
        check({tag, ".res"}, 32'(res1), 32'(m_res));
        check({tag, ".co"}, 32'(res_co1), 32'(m_co));
        check({tag, ".valid"}, 32'(valid1), 32'(m_valid));
        check({tag, ".busy"}, 32'(busy1), 32'(0));
    endtask

    // Hold a button on instance 1 or 3, release, and wait for everything to settle.
    task automatic press(input int which, input int idx, input int hold);
        if (which == 1) btn1[idx] = 1'b1; else btn3[idx] = 1'b1;
        step(hold);
        if (which == 1) btn1[idx] = 1'b0; else btn3[idx] = 1'b0;
        step(12);
    endtask

    // Effect of one accepted press on the model.
    task automatic model_press(input int idx);
        case (idx)
            0: begin m_a = sw; m_valid = 1'b0; end
            1: begin m_b = sw; m_valid = 1'b0; end
            2: begin m_s = m_s + 2'd1; m_valid = 1'b0; end
            3: begin {m_co, m_res} = alu_ref(m_a, m_b, m_s); m_valid = 1'b1; end
            default: if (m_valid) begin m_a = m_res; m_valid = 1'b0; end
        endcase
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] x, y;
        logic [4:0] r3;
        int idx, hold;
        bit glitch;

        rst = 1'b1; sw = '0; btn1 = '0; btn3 = '0;
        m_a = '0; m_b = '0; m_s = '0; m_res = '0; m_co = 1'b0; m_valid = 1'b0;
        #1;
        check_all("reset");
        step(2);
        rst = 1'b0;
        step(2);

        // Operand load timing: A loads at the 7th edge after the first high sample.
        sw = 4'b1010;
        btn1[0] = 1'b1;
        step(6);
        check("a_edge5", 32'(a1), 32'(0));
        step(1);
        check("a_edge6", 32'(a1), 32'(0));
        step(1);
        check("a_edge7", 32'(a1), 32'(4'b1010));
        sw = 4'b1010 ^ 4'($urandom_range(1, 15));
        step(2);
        btn1[0] = 1'b0;
        step(12);
        m_a = 4'b1010;
        check("a_single_load", 32'(a1), 32'(4'b1010));

        sw = 4'b0111;
        press(1, 1, 10);
        model_press(1);
        check("b_load", 32'(b1), 32'(4'b0111));
        check_all("after_b");

        // Glitch rejection, then four clean op steps with wrap.
        press(1, 2, 3);
        check("op_glitch", 32'(s1), 32'(0));
        for (int k = 0; k < 4; k++) begin
            press(1, 2, 6);
            model_press(2);
            check("op_step", 32'(s1), 32'((k + 1) % 4));
        end

        // Execute/capture: 1010 + 0011 = 1101, no carry.
        sw = 4'b0011;
        press(1, 1, 6);
        model_press(1);
        btn1[3] = 1'b1;
        step(7);
        check("go_busy_e6", 32'(busy1), 32'(0));
        step(1);
        check("go_busy_e7", 32'(busy1), 32'(1));
        check("go_valid_e7", 32'(valid1), 32'(0));
        step(1);
        check("go_busy_e8", 32'(busy1), 32'(0));
        check("go_res", 32'(res1), 32'(4'b1101));
        check("go_co", 32'(res_co1), 32'(0));
        check("go_valid", 32'(valid1), 32'(1));
        btn1[3] = 1'b0;
        step(12);
        model_press(3);
        check_all("after_go");
        sw = 4'b0001;
        press(1, 1, 6);
        model_press(1);
        check("b_clears_valid", 32'(valid1), 32'(0));

        // Random presses and glitches against the model.
        for (int k = 0; k < 24; k++) begin
            idx    = $urandom_range(0, NB - 1);
            glitch = ($urandom_range(0, 3) == 0);
            hold   = glitch ? $urandom_range(1, DB - 1) : $urandom_range(DB + 1, DB + 5);
            sw     = 4'($urandom);
            press(1, idx, hold);
            if (!glitch) model_press(idx);
            check_all("rand");
        end

`ifdef ACC_FEEDBACK_EN
        // Accumulator feedback after a 1010 + 0011 capture.
        for (int k = 0; k < 4; k++) begin
            if (m_s != 2'd0) begin
                press(1, 2, 6);
                model_press(2);
            end
        end
        sw = 4'b1010; press(1, 0, 6); model_press(0);
        sw = 4'b0011; press(1, 1, 6); model_press(1);
        press(1, 3, 6); model_press(3);
        check("acc_pre_res", 32'(res1), 32'(4'b1101));
        sw = 4'b0000; press(1, 1, 6); model_press(1);
        sw = 4'b0011; press(1, 1, 6); model_press(1);
        press(1, 3, 6); model_press(3);
        press(1, 4, 6);
        model_press(4);
        check("acc_load", 32'(a1), 32'(4'b1101));
        check("acc_valid", 32'(valid1), 32'(0));
        press(1, 4, 6);
        model_press(4);
        check("acc_ignored", 32'(a1), 32'(4'b1101));
        check_all("after_acc");
`endif

        // Busy lockout on the SETTLE_CYC=3 instance.
        x = 4'($urandom_range(1, 15));
        y = 4'($urandom);
        sw = x; press(3, 0, 6);
        sw = y; press(3, 1, 6);
        check("l_a", 32'(a3), 32'(x));
        sw = ~x;
        btn3[3] = 1'b1;
        step(1);
        btn3[0] = 1'b1;
        step(6);
        check("l_busy_e6", 32'(busy3), 32'(0));
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("l_busy_exec", 32'(busy3), 32'(1));
            check("l_a_hold", 32'(a3), 32'(x));
        end
        step(1);
        r3 = alu_ref(x, y, 2'd0);
        check("l_busy_done", 32'(busy3), 32'(0));
        check("l_res", 32'(res3), 32'(r3[3:0]));
        check("l_co", 32'(res_co3), 32'(r3[4]));
        check("l_valid", 32'(valid3), 32'(1));
        btn3 = '0;
        step(12);
        check("l_a_after", 32'(a3), 32'(x));

        // Reset mid-EXEC with go held through release.
        btn1[3] = 1'b1;
        step(8);
        check("r_busy", 32'(busy1), 32'(1));
        rst = 1'b1;
        #1;
        m_a = '0; m_b = '0; m_s = '0; m_res = '0; m_co = 1'b0; m_valid = 1'b0;
        check_all("r_async");
        check("r_a3", 32'(a3), 32'(0));
        step(2);
        rst = 1'b0;
        step(7);
        check("r_no_early_go", 32'(busy1), 32'(0));
        step(1);
        check("r_go_after_db", 32'(busy1), 32'(1));
        btn1[3] = 1'b0;
        step(12);
        model_press(3);
        check_all("r_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
